ula_nibble_serial: RTL and testbench
====================================

Name: ula_nibble_serial

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit 74181-style ALU.
- Executes the full 16-function logic set and the 16-function arithmetic set on WIDTH-bit operands.
- Reuses one 4-bit slice, one nibble per clock, LSB nibble first; carry chains between nibbles through a register.
- Sits between operand registers and result bus; start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. NIB = WIDTH/4 is the number of nibble cycles.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- s  input  4  function select {S3,S2,S1,S0}
- m  input  1  1 = logic, 0 = arithmetic
- c_in  input  1  carry-in, active-high (adds 1)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, results valid
- f  output  WIDTH  result
- c_out  output  1  carry out of MSB
- a_eq_b  output  1  full-width A==B

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, f=0, c_out=0, a_eq_b=0, FSM=IDLE, internal carry/nibble counter/shift registers=0.
- FSM states: IDLE, RUN.
- IDLE -> RUN: on an edge with start=1. That edge captures a, b, s, m and c_in into internal registers. The carry register loads c_in when m=0 and 0 when m=1. Counter=0, eq accumulator=1. busy=1 after that edge.
- RUN, each edge: process nibble [4*cnt+3:4*cnt] of the captured operands.
  - Shift the 4-bit result into the result shift register.
  - Update the carry register with the slice carry.
  - eq accumulator &= (a_nib==b_nib).
  - cnt++.
- RUN -> IDLE: on the edge that processes nibble NIB-1.
  - f, c_out and a_eq_b load the final values.
  - done=1 for exactly that one cycle; busy=0.
- Latency: start accepted at edge k gives done=1 and valid results after edge k+NIB.
- Start is accepted on the very next edge (done cycle) when start=1; back-to-back throughput is one op per NIB+1 cycles.
- start while busy=1 is ignored. Changes on a/b/s/m/c_in during RUN have no effect.
- f, c_out and a_eq_b hold their last completed values until the next completion. They never show partial results.
- Logic mode (m=1), bitwise over all bits, c_out=0:
  - 0000 ~A, 0001 ~(A|B), 0010 ~A&B, 0011 0
  - 0100 ~(A&B), 0101 ~B, 0110 A^B, 0111 A&~B
  - 1000 A&B, 1001 ~(A^B), 1010 B, 1011 ~A|B
  - 1100 all-ones, 1101 A|~B, 1110 A|B, 1111 A
- Arithmetic mode (m=0): F = X + Y + c_in over WIDTH bits; c_out = carry out of bit WIDTH-1. X,Y by s:
  - 0000 A,0
  - 0001 A|B,0
  - 0010 A|~B,0
  - 0011 0,all-ones
  - 0100 A,A&~B
  - 0101 A|B,A&~B
  - 0110 A,~B
  - 0111 A&~B,all-ones
  - 1000 A,A&B
  - 1001 A,B
  - 1010 A|~B,A&B
  - 1011 A&B,all-ones
  - 1100 A,A
  - 1101 A|B,A
  - 1110 A|~B,A
  - 1111 A,all-ones
- X and Y are formed per nibble; the per-nibble carry chain yields results identical to a WIDTH-bit adder.
- c_out has no inversion for any s: subtract (0110, c_in=1) gives c_out=1 when no borrow.
- a_eq_b is computed in both modes, independent of s.
- rst asserted mid-RUN aborts immediately to reset values. No done pulse is produced and partial results are discarded.
- WIDTH=4 (NIB=1): done one edge after start; results bit-identical to the single-cycle 4-bit ALU for the arithmetic table above.

Test Plan:
- WIDTH=16, m=0, s=1001, a=0x1234, b=0x0FFF, c_in=0, start pulse -> busy for 4 cycles; done after edge k+4; f=0x2233, c_out=0, a_eq_b=0.
- Full carry ripple: m=0, s=1001, a=0xFFFF, b=0x0000, c_in=1 -> f=0x0000, c_out=1.
- Subtract: m=0, s=0110, c_in=1, a=0x1000, b=0x0001 -> f=0x0FFF, c_out=1. Then a=b=0x5A5A -> f=0x0000, c_out=1, a_eq_b=1. Then a=0x0001, b=0x0002 -> f=0xFFFF, c_out=0.
- Logic: m=1, s=0110, a=0xF0F0, b=0xFF00, c_in=1 -> f=0x0FF0, c_out=0. Also s=1100 -> f=0xFFFF.
- Handshake: start held high through an op and operands changed mid-RUN -> no restart while busy, first result unaffected. Second op accepted on the done cycle edge -> done pulses at k+4 and k+9.
- Reset: assert rst asynchronously 2 cycles into RUN -> busy, done, f, c_out, a_eq_b=0 immediately; no done pulse. The next start completes normally.

Source files
------------

// File: rtl/ula_nibble_serial_if.sv
// rtl/ula_nibble_serial_if.sv - operand/result bus for the nibble-serial ALU
interface ula_nibble_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;

  modport master (
    output start, a, b, s, m, c_in,
    input  busy, done, f, c_out, a_eq_b
  );

  modport slave (
    input  start, a, b, s, m, c_in,
    output busy, done, f, c_out, a_eq_b
  );
endinterface

// File: rtl/ula_nibble_serial.sv
// rtl/ula_nibble_serial.sv - 74181-style ALU reusing one 4-bit slice, one nibble per clock
module ula_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ula_nibble_serial_if.slave   bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [3:0]       s_r;
  logic             m_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             eq;
  logic             done_r, c_out_r, a_eq_b_r;
  logic [WIDTH-1:0] f_r;

  logic             accept, last;
  logic [3:0]       an, bn, lf, x, y, f_nib;
  logic [4:0]       sum;
  logic             slice_c, eq_next;
  logic [WIDTH+3:0] res_cat;
  logic [WIDTH-1:0] res_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NIB - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign an = a_sh[3:0];
  assign bn = b_sh[3:0];

  always_comb begin
    lf = 4'h0;
    unique case (s_r)
      4'b0000: lf = ~an;
      4'b0001: lf = ~(an | bn);
      4'b0010: lf = ~an & bn;
      4'b0011: lf = 4'h0;
      4'b0100: lf = ~(an & bn);
      4'b0101: lf = ~bn;
      4'b0110: lf = an ^ bn;
      4'b0111: lf = an & ~bn;
      4'b1000: lf = an & bn;
      4'b1001: lf = ~(an ^ bn);
      4'b1010: lf = bn;
      4'b1011: lf = ~an | bn;
      4'b1100: lf = 4'hF;
      4'b1101: lf = an | ~bn;
      4'b1110: lf = an | bn;
      4'b1111: lf = an;
    endcase
  end

  always_comb begin
    x = an;
    y = 4'h0;
    unique case (s_r)
      4'b0000: begin x = an;        y = 4'h0;      end
      4'b0001: begin x = an | bn;   y = 4'h0;      end
      4'b0010: begin x = an | ~bn;  y = 4'h0;      end
      4'b0011: begin x = 4'h0;      y = 4'hF;      end
      4'b0100: begin x = an;        y = an & ~bn;  end
      4'b0101: begin x = an | bn;   y = an & ~bn;  end
      4'b0110: begin x = an;        y = ~bn;       end
      4'b0111: begin x = an & ~bn;  y = 4'hF;      end
      4'b1000: begin x = an;        y = an & bn;   end
      4'b1001: begin x = an;        y = bn;        end
      4'b1010: begin x = an | ~bn;  y = an & bn;   end
      4'b1011: begin x = an & bn;   y = 4'hF;      end
      4'b1100: begin x = an;        y = an;        end
      4'b1101: begin x = an | bn;   y = an;        end
      4'b1110: begin x = an | ~bn;  y = an;        end
      4'b1111: begin x = an;        y = 4'hF;      end
    endcase
  end

  // Logic mode never propagates a carry, so the chain stays at 0 between nibbles.
  assign sum      = {1'b0, x} + {1'b0, y} + {4'h0, carry};
  assign f_nib    = m_r ? lf : sum[3:0];
  assign slice_c  = m_r ? 1'b0 : sum[4];
  assign eq_next  = eq & (an == bn);
  assign res_cat  = {f_nib, res};
  assign res_next = res_cat[WIDTH+3:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      s_r      <= 4'h0;
      m_r      <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
      eq       <= 1'b0;
      done_r   <= 1'b0;
      f_r      <= '0;
      c_out_r  <= 1'b0;
      a_eq_b_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        s_r   <= bus.s;
        m_r   <= bus.m;
        carry <= bus.m ? 1'b0 : bus.c_in;
        cnt   <= '0;
        eq    <= 1'b1;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 4;
        b_sh  <= b_sh >> 4;
        res   <= res_next;
        carry <= slice_c;
        eq    <= eq_next;
        cnt   <= cnt + 1'b1;
        if (last) begin
          f_r      <= res_next;
          c_out_r  <= slice_c;
          a_eq_b_r <= eq_next;
          done_r   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_r;
  assign bus.f      = f_r;
  assign bus.c_out  = c_out_r;
  assign bus.a_eq_b = a_eq_b_r;
endmodule

// File: tb/tb_ula_nibble_serial.sv
// tb/tb_ula_nibble_serial.sv - randomized and directed bench for the nibble-serial ALU
module tb_ula_nibble_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_nibble_serial_if #(.WIDTH(16)) bus ();
  ula_nibble_serial_if #(.WIDTH(4))  bus4 ();

  ula_nibble_serial #(.WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  ula_nibble_serial #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // Whole-word reference: the result is what a single w-bit 74181 would give.
  function automatic void model(input int w, input logic [15:0] a_i, input logic [15:0] b_i,
                                input logic [3:0] s_i, input logic m_i, input logic c_i,
                                output logic [15:0] f_o, output logic c_o);
    logic [31:0] mask, aa, bb, r, x, y;
    mask = (32'd1 << w) - 32'd1;
    aa = {16'h0, a_i} & mask;
    bb = {16'h0, b_i} & mask;
    r = 0; x = 0; y = 0;
    if (m_i) begin
      case (s_i)
        4'h0: r = ~aa;        4'h1: r = ~(aa | bb);  4'h2: r = ~aa & bb;    4'h3: r = 0;
        4'h4: r = ~(aa & bb); 4'h5: r = ~bb;         4'h6: r = aa ^ bb;     4'h7: r = aa & ~bb;
        4'h8: r = aa & bb;    4'h9: r = ~(aa ^ bb);  4'hA: r = bb;          4'hB: r = ~aa | bb;
        4'hC: r = mask;       4'hD: r = aa | ~bb;    4'hE: r = aa | bb;     4'hF: r = aa;
      endcase
      f_o = r[15:0] & mask[15:0];
      c_o = 1'b0;
    end else begin
      case (s_i)
        4'h0: begin x = aa;       y = 0;        end
        4'h1: begin x = aa | bb;  y = 0;        end
        4'h2: begin x = aa | ~bb; y = 0;        end
        4'h3: begin x = 0;        y = mask;     end
        4'h4: begin x = aa;       y = aa & ~bb; end
        4'h5: begin x = aa | bb;  y = aa & ~bb; end
        4'h6: begin x = aa;       y = ~bb;      end
        4'h7: begin x = aa & ~bb; y = mask;     end
        4'h8: begin x = aa;       y = aa & bb;  end
        4'h9: begin x = aa;       y = bb;       end
        4'hA: begin x = aa | ~bb; y = aa & bb;  end
        4'hB: begin x = aa & bb;  y = mask;     end
        4'hC: begin x = aa;       y = aa;       end
        4'hD: begin x = aa | bb;  y = aa;       end
        4'hE: begin x = aa | ~bb; y = aa;       end
        4'hF: begin x = aa;       y = mask;     end
      endcase
      r = (x & mask) + (y & mask) + {31'h0, c_i};
      f_o = r[15:0] & mask[15:0];
      c_o = r[w];
    end
  endfunction

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is,
                        input logic im, input logic ic, output logic [15:0] of,
                        output logic oc, output logic oeq, output int lat);
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.s = is; bus.m = im; bus.c_in = ic; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 20 && bus.done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    of = bus.f; oc = bus.c_out; oeq = bus.a_eq_b;
  endtask

  task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] is,
                         input logic im, input logic ic, output logic [3:0] of,
                         output logic oc, output logic oeq, output int lat);
    @(negedge clk);
    bus4.a = ia; bus4.b = ib; bus4.s = is; bus4.m = im; bus4.c_in = ic; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0;
    while (lat < 20 && bus4.done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus4.done !== 1'b1) lat = -1;
    of = bus4.f; oc = bus4.c_out; oeq = bus4.a_eq_b;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.a = 0; bus.b = 0; bus.s = 0; bus.m = 0; bus.c_in = 0;
    bus4.start = 0; bus4.a = 0; bus4.b = 0; bus4.s = 0; bus4.m = 0; bus4.c_in = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.f, bus.c_out, bus.a_eq_b} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b f=%h c_out=%b a_eq_b=%b want all 0",
               bus.busy, bus.done, bus.f, bus.c_out, bus.a_eq_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b; logic [3:0] s; logic m, c; logic [15:0] f; logic co, eq;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    logic [15:0] gf; logic gc, ge; int lat;
    v[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    v[3] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    v[4] = '{16'h0001, 16'h0002, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    v[5] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0};
    v[6] = '{16'hF0F0, 16'hFF00, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, v[i].m, v[i].c, gf, gc, ge, lat);
      checks++;
      if (lat !== 4 || gf !== v[i].f || gc !== v[i].co || ge !== v[i].eq) begin
        failures++;
        $display("FAIL directed[%0d] got lat=%0d f=%h c=%b eq=%b want lat=4 f=%h c=%b eq=%b",
                 i, lat, gf, gc, ge, v[i].f, v[i].co, v[i].eq);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, gf, ef; logic [3:0] rs; logic rm, rc, gc, ge, ec; int lat;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
      model(16, ra, rb, rs, rm, rc, ef, ec);
      run_op(ra, rb, rs, rm, rc, gf, gc, ge, lat);
      checks++;
      if (lat !== 4 || gf !== ef || gc !== ec || ge !== (ra == rb)) begin
        failures++;
        $display("FAIL random a=%h b=%h s=%b m=%b c=%b got lat=%0d f=%h c=%b eq=%b want f=%h c=%b eq=%b",
                 ra, rb, rs, rm, rc, lat, gf, gc, ge, ef, ec, ra == rb);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, ndone;
    logic [15:0] f1, f2;
    d1 = -1; d2 = -1; ndone = 0; f1 = 0; f2 = 0;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.s = 4'b1001; bus.m = 0; bus.c_in = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.a = 16'h0F0F; bus.b = 16'h0101; bus.c_in = 1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (d1 < 0) begin d1 = e; f1 = bus.f; end
        else if (d2 < 0) begin d2 = e; f2 = bus.f; end
      end
      if (e == 5) bus.start = 0;
    end
    checks++;
    if (d1 !== 4 || f1 !== 16'h2233) begin
      failures++;
      $display("FAIL b2b_first got edge=%0d f=%h want edge=4 f=2233", d1, f1);
    end
    checks++;
    if (d2 !== 9 || f2 !== 16'h1011 || ndone !== 2) begin
      failures++;
      $display("FAIL b2b_second got edge=%0d f=%h pulses=%0d want edge=9 f=1011 pulses=2", d2, f2, ndone);
    end
  endtask

  task automatic test_abort();
    logic [15:0] gf; logic gc, ge; int lat, nd;
    run_op(16'hFFFF, 16'hFFFF, 4'b1001, 1'b0, 1'b1, gf, gc, ge, lat);
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.s = 4'b1001; bus.m = 0; bus.c_in = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.f, bus.c_out, bus.a_eq_b} !== 20'h0) begin
      failures++;
      $display("FAIL abort_state got busy=%b done=%b f=%h c_out=%b a_eq_b=%b want all 0",
               bus.busy, bus.done, bus.f, bus.c_out, bus.a_eq_b);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done got active_cycles=%0d want 0", nd);
    end
    run_op(16'h0001, 16'h0002, 4'b0110, 1'b0, 1'b1, gf, gc, ge, lat);
    checks++;
    if (lat !== 4 || gf !== 16'hFFFF || gc !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover got lat=%0d f=%h c=%b want lat=4 f=ffff c=0", lat, gf, gc);
    end
  endtask

  task automatic test_width4();
    logic [3:0] ra, rb, rs, gf; logic [15:0] ef; logic rm, rc, gc, ge, ec; int lat;
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 4'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      model(4, {12'h0, ra}, {12'h0, rb}, rs, rm, rc, ef, ec);
      run_op4(ra, rb, rs, rm, rc, gf, gc, ge, lat);
      checks++;
      if (lat !== 1 || gf !== ef[3:0] || gc !== ec || ge !== (ra == rb)) begin
        failures++;
        $display("FAIL width4 a=%h b=%h s=%b m=%b c=%b got lat=%0d f=%h c=%b eq=%b want lat=1 f=%h c=%b eq=%b",
                 ra, rb, rs, rm, rc, lat, gf, gc, ge, ef[3:0], ec, ra == rb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
